// File: rtl/kernel_filter.sv
// kernel_filter: streams a 1-bit WIDTHxHEIGHT frame out of a source BRAM in raster
// order, applies a 3x3 pass/majority/erode/dilate kernel and writes the result to a
// destination BRAM. Defining KERNEL_FILTER_STATS_EN adds ones_count_out, a running
// count of 1-pixels written in the current frame.
module kernel_filter #(
   parameter int unsigned WIDTH  = 480,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned THRESH = 5,
   parameter int unsigned ADDR_W = 20
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic [1:0]        mode_in,
   output logic [ADDR_W-1:0] src_addr_out,
   output logic              src_en_out,
   input  logic              src_data_in,
   output logic [ADDR_W-1:0] dst_addr_out,
   output logic              dst_data_out,
   output logic              dst_we_out,
`ifdef KERNEL_FILTER_STATS_EN
   output logic [ADDR_W:0]   ones_count_out,
`endif
   output logic              busy_out,
   output logic              done_out
);

   localparam int unsigned N  = WIDTH * HEIGHT;
   localparam int unsigned KW = ADDR_W + 1;
   localparam int unsigned CW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
   localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [KW-1:0] K_N      = KW'(N);
   localparam logic [KW-1:0] K_LAST   = KW'(N + WIDTH);
   localparam logic [KW-1:0] K_FIRST  = KW'(WIDTH + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [1:0]    MODE_PASS = 2'b00;
   localparam logic [1:0]    MODE_MAJ  = 2'b01;
   localparam logic [1:0]    MODE_ERO  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [KW-1:0]       k_q, k_d;
   logic [1:0]          drain_q, drain_d;
   logic [1:0]          mode_q, mode_d;
   logic                src_en_d, busy_d, done_d;
   logic [ADDR_W-1:0]   src_addr_d;
   logic                accept;

   // stream-to-window alignment: the BRAM returns data two cycles after the read
   logic                st_d1, st_d2, en_d1, en_d2;
   logic [KW-1:0]       kcnt;
   logic [CW-1:0]       wptr, ccol;
   logic [RW-1:0]       crow;
   logic [ADDR_W-1:0]   c_addr;
   logic                lb0 [WIDTH];
   logic                lb1 [WIDTH];
   logic [2:0]          top_q, mid_q, bot_q;
   logic [2:0]          top_n, mid_n, bot_n, top_m, mid_m, bot_m, col_m;
   logic                pix, f_bit, wr;
   logic [3:0]          ones;

   assign accept = (state_q == S_IDLE) && start_in;

   // next-state and registered-output decode
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      drain_d    = drain_q;
      mode_d     = mode_q;
      src_en_d   = 1'b0;
      src_addr_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_SCAN;
               k_d     = '0;
               mode_d  = mode_in;
            end
         end
         S_SCAN: begin
            if (k_q == K_LAST) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == 2'd2) state_d = S_DONE;
            else                 drain_d = drain_q + 2'd1;
         end
         default: state_d = S_IDLE;
      endcase
      src_en_d   = (state_d == S_SCAN) && (k_d < K_N);
      src_addr_d = src_en_d ? ADDR_W'(k_d) : '0;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   // state register and control outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         drain_q      <= '0;
         mode_q       <= '0;
         src_en_out   <= 1'b0;
         src_addr_out <= '0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         drain_q      <= drain_d;
         mode_q       <= mode_d;
         src_en_out   <= src_en_d;
         src_addr_out <= src_addr_d;
         busy_out     <= busy_d;
         done_out     <= done_d;
      end
   end

   // next window including the arriving pixel, edge masking and kernel function
   always_comb begin
      pix   = en_d2 & src_data_in;
      top_n = {lb1[wptr], top_q[2:1]};
      mid_n = {lb0[wptr], mid_q[2:1]};
      bot_n = {pix, bot_q[2:1]};
      col_m = {ccol != COL_LAST, 1'b1, ccol != '0};
      top_m = top_n & col_m & {3{crow != '0}};
      mid_m = mid_n & col_m;
      bot_m = bot_n & col_m & {3{crow != ROW_LAST}};
      ones  = '0;
      for (int i = 0; i < 3; i++)
         ones = ones + 4'(top_m[i]) + 4'(mid_m[i]) + 4'(bot_m[i]);
      case (mode_q)
         MODE_PASS: f_bit = mid_m[1];
         MODE_MAJ:  f_bit = (ones >= 4'(THRESH));
         MODE_ERO:  f_bit = (ones == 4'd9);
         default:   f_bit = (ones != 4'd0);
      endcase
      wr = st_d2 && (kcnt >= K_FIRST);
   end

   // window, centre position tracking and destination write port
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         st_d1        <= 1'b0;
         st_d2        <= 1'b0;
         en_d1        <= 1'b0;
         en_d2        <= 1'b0;
         kcnt         <= '0;
         wptr         <= '0;
         ccol         <= '0;
         crow         <= '0;
         c_addr       <= '0;
         top_q        <= '0;
         mid_q        <= '0;
         bot_q        <= '0;
         dst_we_out   <= 1'b0;
         dst_data_out <= 1'b0;
         dst_addr_out <= '0;
      end else begin
         st_d1        <= (state_q == S_SCAN);
         st_d2        <= st_d1;
         en_d1        <= src_en_out;
         en_d2        <= en_d1;
         dst_we_out   <= wr;
         dst_data_out <= wr & f_bit;
         dst_addr_out <= wr ? c_addr : '0;
         if (accept) begin
            kcnt   <= '0;
            wptr   <= '0;
            ccol   <= '0;
            crow   <= '0;
            c_addr <= '0;
         end else begin
            if (st_d2) begin
               top_q <= top_n;
               mid_q <= mid_n;
               bot_q <= bot_n;
               kcnt  <= kcnt + KW'(1);
               wptr  <= (wptr == COL_LAST) ? '0 : wptr + CW'(1);
            end
            if (wr) begin
               c_addr <= c_addr + ADDR_W'(1);
               if (ccol == COL_LAST) begin
                  ccol <= '0;
                  crow <= (crow == ROW_LAST) ? '0 : crow + RW'(1);
               end else begin
                  ccol <= ccol + CW'(1);
               end
            end
         end
      end
   end

   // two row-delay line buffers; contents are stale until overwritten by the frame
   always_ff @(posedge clk_in) begin
      if (st_d2) begin
         lb0[wptr] <= pix;
         lb1[wptr] <= lb0[wptr];
      end
   end

`ifdef KERNEL_FILTER_STATS_EN
   // count of 1-pixels written in the current frame
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)          ones_count_out <= '0;
      else if (accept)      ones_count_out <= '0;
      else if (wr && f_bit) ones_count_out <= ones_count_out + KW'(1);
   end
`endif

endmodule

// File: tb/tb_kernel_filter.sv
// Self-checking bench for kernel_filter on a 4x3 frame.
module tb_kernel_filter;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = 8;
   localparam int TH = 5;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          start_in = 1'b0;
   logic [1:0]    mode_in = 2'b00;
   logic [AW-1:0] src_addr_out;
   logic          src_en_out;
   logic          src_data_in = 1'b0;
   logic [AW-1:0] dst_addr_out;
   logic          dst_data_out;
   logic          dst_we_out;
   logic          busy_out;
   logic          done_out;
`ifdef KERNEL_FILTER_STATS_EN
   logic [AW:0]   ones_count_out;
`endif

   int n_vec = 0;
   int n_err = 0;

   bit   img [1 << AW];
   logic rd_pipe = 1'b0;

   kernel_filter #(.WIDTH(W), .HEIGHT(H), .THRESH(TH), .ADDR_W(AW)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .start_in     (start_in),
      .mode_in      (mode_in),
      .src_addr_out (src_addr_out),
      .src_en_out   (src_en_out),
      .src_data_in  (src_data_in),
      .dst_addr_out (dst_addr_out),
      .dst_data_out (dst_data_out),
      .dst_we_out   (dst_we_out),
`ifdef KERNEL_FILTER_STATS_EN
      .ones_count_out (ones_count_out),
`endif
      .busy_out     (busy_out),
      .done_out     (done_out)
   );

   always #5 clk_in = ~clk_in;

   // source BRAM with 2-cycle latency; returns junk when not enabled
   always @(posedge clk_in) begin
      rd_pipe     <= src_en_out ? img[src_addr_out] : 1'($urandom);
      src_data_in <= rd_pipe;
   end

   // reference kernel computed directly on the image
   function automatic bit ref_pix(input int c, input logic [1:0] m);
      int r, col, ones;
      r = c / W;
      col = c % W;
      ones = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && col + dc >= 0 && col + dc < W)
               ones += int'(img[(r + dr) * W + col + dc]);
      case (m)
         2'b00:   return img[c];
         2'b01:   return ones >= TH;
         2'b10:   return ones == 9;
         default: return ones > 0;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // call at a negedge with the DUT idle; start is accepted at the next posedge
   task automatic run_frame(input logic [1:0] mode, input bit extra_starts, output int ones_obs);
      bit exp_img [N];
      int wr_idx, exp_ones;
      exp_ones = 0;
      for (int c = 0; c < N; c++) begin
         exp_img[c] = ref_pix(c, mode);
         exp_ones += int'(exp_img[c]);
      end
      wr_idx = 0;
      ones_obs = 0;
      start_in = 1'b1;
      mode_in = mode;
      for (int j = 1; j <= N + W + 8; j++) begin
         @(negedge clk_in);
         check("busy", int'(busy_out), int'(j <= N + W + 5));
         check("done", int'(done_out), int'(j == N + W + 5));
         check("src_en", int'(src_en_out), int'(j - 1 < N));
         if (j - 1 < N) check("src_addr", int'(src_addr_out), j - 1);
         if (dst_we_out) begin
            if (wr_idx < N) begin
               check("dst_addr", int'(dst_addr_out), wr_idx);
               check("dst_data", int'(dst_data_out), int'(exp_img[wr_idx]));
               check("dst_cycle", j, wr_idx + W + 5);
            end
            ones_obs += int'(dst_data_out);
            wr_idx++;
         end
         start_in = extra_starts && (j == 5 || j == N + W + 5);
         mode_in = 2'($urandom);
      end
      check("wr_count", wr_idx, N);
`ifdef KERNEL_FILTER_STATS_EN
      check("ones_count", int'(ones_count_out), exp_ones);
`endif
   endtask

   initial begin
      int ones;
      logic [1:0] m;
      repeat (3) @(negedge clk_in);
      check("rst_busy", int'(busy_out), 0);
      check("rst_src_en", int'(src_en_out), 0);
      check("rst_dst_we", int'(dst_we_out), 0);
      check("rst_done", int'(done_out), 0);
      rst_in = 1'b1;
      @(negedge clk_in);

      // all ones, majority: corners drop out
      for (int c = 0; c < N; c++) img[c] = 1'b1;
      run_frame(2'b01, 1'b0, ones);
      check("maj_ones", ones, 8);

      // single pixel dilate / erode
      for (int c = 0; c < N; c++) img[c] = (c == 5);
      run_frame(2'b11, 1'b0, ones);
      check("dil_ones", ones, 9);
      run_frame(2'b10, 1'b0, ones);
      check("ero_ones", ones, 0);

      // checkerboard pass-through
      for (int c = 0; c < N; c++) img[c] = bit'(((c / W) + (c % W)) % 2);
      run_frame(2'b00, 1'b0, ones);
      check("pass_ones", ones, 6);

      // starts while busy and during DONE are ignored
      for (int c = 0; c < N; c++) img[c] = 1'($urandom);
      run_frame(2'b01, 1'b1, ones);

      // reset mid-frame aborts, restart is accepted on the first edge
      start_in = 1'b1;
      mode_in = 2'b11;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk_in);
         start_in = 1'b0;
      end
      rst_in = 1'b0;
      #1;
      check("abort_busy", int'(busy_out), 0);
      check("abort_src_en", int'(src_en_out), 0);
      check("abort_src_addr", int'(src_addr_out), 0);
      check("abort_dst_we", int'(dst_we_out), 0);
      check("abort_dst_addr", int'(dst_addr_out), 0);
      check("abort_done", int'(done_out), 0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk_in);
         check("abort_hold_we", int'(dst_we_out), 0);
         check("abort_hold_done", int'(done_out), 0);
      end
      rst_in = 1'b1;
      for (int c = 0; c < N; c++) img[c] = 1'($urandom);
      run_frame(2'b01, 1'b0, ones);

      // random frames in random modes
      for (int f = 0; f < 6; f++) begin
         for (int c = 0; c < N; c++) img[c] = 1'($urandom);
         m = 2'($urandom);
         run_frame(m, 1'b0, ones);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
